// File: rtl/coincidence_window.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// coincidence_window
//
// Event qualifier between the 24 scintillator discriminator inputs and the
// hit latch / SPI readout stage. Raw hits are synchronized and edge-detected.
// The first edge opens a fixed coincidence window. Edges seen during the window
// are OR-accumulated into a mask. When the window closes, the mask is accepted
// only if enough plane pairs (bits [2k+1:2k]) are non-empty. An accepted mask
// is held on hit_out. A dead time follows both accept and reject.
//
// Parameters:
//   WINDOW_CYCLES  window length in clocks, including the entry cycle (1..255)
//   HOLD_CYCLES    clocks hit_out is held after an accept (1..255)
//   DEAD_CYCLES    clocks edges are ignored after the window closes (1..255)
//   MIN_PAIRS      minimum non-empty plane pairs needed to accept (1..12)
//
// Ports:
//   sys_clk        PLL system clock
//   rst_n          asynchronous active-low reset
//   hit_raw[23:0]  asynchronous discriminator outputs
//   arm            enables event capture; low during a window aborts it
//   cnt_clr        synchronous clear of the statistics counters
//   hit_out[23:0]  accepted mask while in HOLD, 0 otherwise
//   event_valid    one-cycle pulse on accept
//   event_reject   one-cycle pulse on reject
//   busy           high in WINDOW, HOLD and DEAD
//   accept_count   saturating count of accepted events
//   reject_count   saturating count of rejected events
//
// Build option: define COINC_STATS_EN to compile in the accept/reject
// counters. Without it both counts are tied to 0 and cnt_clr is unused.
// -----------------------------------------------------------------------------
module coincidence_window #(
  parameter int unsigned WINDOW_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES   = 4,
  parameter int unsigned DEAD_CYCLES   = 32,
  parameter int unsigned MIN_PAIRS     = 12
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [23:0] hit_raw,
  input  logic        arm,
  input  logic        cnt_clr,
  output logic [23:0] hit_out,
  output logic        event_valid,
  output logic        event_reject,
  output logic        busy,
  output logic [15:0] accept_count,
  output logic [15:0] reject_count
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WINDOW,
    ST_HOLD,
    ST_DEAD
  } state_t;

  // Timers count down to zero, so a phase of N cycles is loaded with N-1.
  localparam logic [7:0] WIN_LOAD  = 8'(WINDOW_CYCLES - 1);
  localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_CYCLES - 1);
  localparam logic [3:0] MIN_PAIRS_L = 4'(MIN_PAIRS);

  // Number of plane pairs with at least one bit set.
  function automatic logic [3:0] count_pairs(input logic [23:0] m);
    logic [3:0] n;
    n = '0;
    for (int k = 0; k < 12; k++) begin
      n = n + 4'(m[2*k] | m[2*k+1]);
    end
    return n;
  endfunction

  // ---------------------------------------------------------------------------
  // Input path: two-flop synchronizer, then a "prev" flop for edge detection.
  // ---------------------------------------------------------------------------
  logic [23:0] sync1, sync2, prev;
  logic [23:0] hit_edge;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its source, which is what makes the chain a pipeline.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= hit_raw;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign hit_edge = sync2 & ~prev;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  state_t      state, state_nxt;
  logic [7:0]  timer, timer_nxt;
  logic [23:0] mask, mask_nxt;
  logic [23:0] hit_nxt;
  logic        valid_nxt, reject_nxt;
  logic [23:0] final_mask;
  logic [3:0]  pair_cnt;

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      timer        <= '0;
      mask         <= '0;
      hit_out      <= '0;
      event_valid  <= 1'b0;
      event_reject <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      mask         <= mask_nxt;
      hit_out      <= hit_nxt;
      event_valid  <= valid_nxt;
      event_reject <= reject_nxt;
      busy         <= (state_nxt != ST_IDLE);
    end
  end

  // The mask including this cycle's edges, so the last window cycle counts.
  assign final_mask = mask | hit_edge;
  assign pair_cnt   = count_pairs(final_mask);

  // NOTE: every signal written here gets a default first; a path that skipped
  // an assignment would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    timer_nxt  = timer;
    mask_nxt   = mask;
    hit_nxt    = hit_out;
    valid_nxt  = 1'b0;
    reject_nxt = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (arm && (|hit_edge)) begin
          mask_nxt  = hit_edge;
          timer_nxt = WIN_LOAD;
          state_nxt = ST_WINDOW;
        end
      end

      ST_WINDOW: begin
        // Dropping arm wins over a close in the same cycle: the event vanishes.
        if (!arm) begin
          mask_nxt  = '0;
          timer_nxt = '0;
          state_nxt = ST_IDLE;
        end else if (timer == '0) begin
          if (pair_cnt >= MIN_PAIRS_L) begin
            mask_nxt  = final_mask;
            hit_nxt   = final_mask;
            valid_nxt = 1'b1;
            timer_nxt = HOLD_LOAD;
            state_nxt = ST_HOLD;
          end else begin
            mask_nxt   = '0;
            reject_nxt = 1'b1;
            timer_nxt  = DEAD_LOAD;
            state_nxt  = ST_DEAD;
          end
        end else begin
          mask_nxt  = final_mask;
          timer_nxt = timer - 8'd1;
        end
      end

      ST_HOLD: begin
        if (timer == '0) begin
          hit_nxt   = '0;
          mask_nxt  = '0;
          timer_nxt = DEAD_LOAD;
          state_nxt = ST_DEAD;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end

      ST_DEAD: begin
        if (timer == '0) begin
          state_nxt = ST_IDLE;
        end else begin
          timer_nxt = timer - 8'd1;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Statistics counters
  // ---------------------------------------------------------------------------
`ifdef COINC_STATS_EN
  logic [15:0] accept_q, reject_q;

  // Counters step on the same edge that raises the pulse, so a count and its
  // pulse always appear together.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      accept_q <= '0;
      reject_q <= '0;
    end else if (cnt_clr) begin
      accept_q <= '0;
      reject_q <= '0;
    end else begin
      if (valid_nxt && (accept_q != 16'hFFFF)) begin
        accept_q <= accept_q + 16'd1;
      end
      if (reject_nxt && (reject_q != 16'hFFFF)) begin
        reject_q <= reject_q + 16'd1;
      end
    end
  end

  assign accept_count = accept_q;
  assign reject_count = reject_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign accept_count   = '0;
  assign reject_count   = '0;
`endif

endmodule
